// File: rtl/axil_cfg_rd_arb.sv
// axil_cfg_rd_arb: two-requester round-robin read arbiter in front of
// a single-outstanding config read master.
// Ports: s_axi_aclk/s_axi_areset (sync, active-high); reqN_rvalid,
// reqN_raddr, reqN_rready, reqN_rdata, reqN_rdv per requester;
// m_cfg_rvalid, m_cfg_raddr, m_cfg_rready, m_cfg_rdata, m_cfg_rdv
// downstream; rd_err timeout completion pulse.
// Option: AXIL_ARB_TIMEOUT_EN enables the WAIT timeout counter.
module axil_cfg_rd_arb #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              req0_rvalid,
  input  logic [ADDR_W-1:0] req0_raddr,
  output logic              req0_rready,
  output logic [31:0]       req0_rdata,
  output logic              req0_rdv,
  input  logic              req1_rvalid,
  input  logic [ADDR_W-1:0] req1_raddr,
  output logic              req1_rready,
  output logic [31:0]       req1_rdata,
  output logic              req1_rdv,
  output logic              m_cfg_rvalid,
  output logic [ADDR_W-1:0] m_cfg_raddr,
  input  logic              m_cfg_rready,
  input  logic [31:0]       m_cfg_rdata,
  input  logic              m_cfg_rdv,
  output logic              rd_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_to_chk
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } st_t;

  st_t               st_q, st_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              win;
  logic              any_v;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tmo;
  // cnt_q counts completed WAIT cycles, so this fires
  // in the TIMEOUT_CYCLES-th WAIT cycle.
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Contended: the side not served last wins.
  always_comb begin
    any_v = req0_rvalid | req1_rvalid;
    unique case (1'b1)
      req0_rvalid && req1_rvalid:  win = ~last_q;
      !req0_rvalid && req1_rvalid: win = 1'b1;
      default:                     win = 1'b0;
    endcase
  end

  always_comb begin
    st_d        = st_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    data_d      = data_q;
    req0_rready = 1'b0;
    req1_rready = 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (st_q)
      IDLE: begin
        if (any_v) begin
          req0_rready = ~win;
          req1_rready = win;
          gnt_d       = win;
          addr_d      = win ? req1_raddr
                            : req0_raddr;
          st_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (m_cfg_rready) begin
          st_d  = WAIT;
`ifdef AXIL_ARB_TIMEOUT_EN
          cnt_d = '0;
          err_d = 1'b0;
`endif
        end
      end
      WAIT: begin
        if (m_cfg_rdv) begin
          data_d = m_cfg_rdata;
          st_d   = RESP;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        else if (tmo) begin
          data_d = 32'hDEAD_BEEF;
          err_d  = 1'b1;
          st_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        last_d = gnt_q;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
    // No grant may leak out while reset is held.
    if (s_axi_areset) begin
      req0_rready = 1'b0;
      req1_rready = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      st_q   <= IDLE;
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q  <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
      addr_q <= addr_d;
      data_q <= data_d;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q  <= cnt_d;
      err_q  <= err_d;
`endif
    end
  end

  assign m_cfg_rvalid = (st_q == ISSUE);
  assign m_cfg_raddr  = m_cfg_rvalid ? addr_q : '0;
  assign req0_rdv     = (st_q == RESP) && !gnt_q;
  assign req1_rdv     = (st_q == RESP) && gnt_q;
  assign req0_rdata   = req0_rdv ? data_q : '0;
  assign req1_rdata   = req1_rdv ? data_q : '0;

`ifdef AXIL_ARB_TIMEOUT_EN
  assign rd_err = (st_q == RESP) && err_q;
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_axil_cfg_rd_arb.sv
// tb_axil_cfg_rd_arb: random + directed scoreboard bench
// for axil_cfg_rd_arb.
module tb_axil_cfg_rd_arb;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0rdy, r1rdy, r0dv, r1dv;
  logic [31:0]   r0d, r1d;
  logic          m_v, m_rdy, m_dv, err;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  logic          rv [2];
  logic [AW-1:0] ra [2];

  always #5 clk = ~clk;

  axil_cfg_rd_arb #(
    .TIMEOUT_CYCLES(TO),
    .ADDR_W(AW)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_areset(rst),
    .req0_rvalid(rv[0]),
    .req0_raddr(ra[0]),
    .req0_rready(r0rdy),
    .req0_rdata(r0d),
    .req0_rdv(r0dv),
    .req1_rvalid(rv[1]),
    .req1_raddr(ra[1]),
    .req1_rready(r1rdy),
    .req1_rdata(r1d),
    .req1_rdv(r1dv),
    .m_cfg_rvalid(m_v),
    .m_cfg_raddr(m_addr),
    .m_cfg_rready(m_rdy),
    .m_cfg_rdata(m_data),
    .m_cfg_rdv(m_dv),
    .rd_err(err)
  );

  typedef struct {
    bit            idx;
    logic [AW-1:0] addr;
  } iss_t;
  typedef struct {
    bit          idx;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  bit   glog[$];
  logic [AW-1:0] mlog[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit rst_e = 0;
  int rst_gen = 0;

  bit   outst = 0;
  bit   last_m = 1;
  bit   acc [2] = '{0, 0};
  bit   iss_chk = 0;
  bit   hs_flag = 0;
  iss_t hs_item;
  int   hs_cyc = -1;
  int   mv_rise = -1;
  bit   prev_mv = 0;
  int   bp_cnt = 0;

  bit   hold_req = 0;
  bit   auto_req = 0;
  int   rdy_mode = 0;
  int   fix_dly = -1;
  bit   frc_en = 0;
  logic [31:0] frc_data = 0;
  bit   silent = 0;
  bit   spur_en = 0;
  bit   rbusy = 0;

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= rst;
  end

  // Monitor: compares DUT outputs with the model
  // and the expectation queues.
  always @(negedge clk) begin : mon
    logic [1:0] er;
    bit   w;
    iss_t it;
    rsp_t r;
    er = 2'b00;
    w  = 1'b0;
    if (rst_e) begin
      outst   = 0;
      last_m  = 1;
      iss_chk = 0;
      rst_gen++;
      iss_q.delete();
      rsp_q.delete();
      chk("rst_outs",
          |{m_v, m_addr, r0dv, r1dv,
            r0d, r1d, err}, 0);
    end
    if (iss_chk) begin
      iss_chk = 0;
      chk("issue_lat", m_v, 1);
    end
    if (!rst && !outst && (rv[0] || rv[1])) begin
      w  = (rv[0] && rv[1]) ? !last_m : rv[1];
      er = w ? 2'b10 : 2'b01;
    end
    chk("rready", {r1rdy, r0rdy}, er);
    if (r0rdy || r1rdy) begin
      glog.push_back(r1rdy);
      acc[r1rdy ? 1 : 0] = 1;
    end
    if (er != 2'b00) begin
      outst   = 1;
      last_m  = w;
      iss_chk = 1;
      it.idx  = w;
      it.addr = ra[w];
      iss_q.push_back(it);
    end
    if (m_v && !prev_mv) mv_rise = cyc;
    prev_mv = m_v;
    if (m_v) begin
      if (iss_q.size() == 0) begin
        chk("issue_unexp", 1, 0);
      end else begin
        chk("raddr", m_addr, iss_q[0].addr);
        if (!m_rdy && !rst) bp_cnt++;
        if (m_rdy && !rst) begin
          hs_item = iss_q.pop_front();
          hs_flag = 1;
          hs_cyc  = cyc;
          mlog.push_back(m_addr);
        end
      end
    end else begin
      chk("raddr_idle", m_addr, 0);
    end
    if (r0dv || r1dv) begin
      chk("rdv_onehot", r0dv && r1dv, 0);
      if (rsp_q.size() == 0) begin
        chk("rdv_unexp", 1, 0);
      end else begin
        r = rsp_q.pop_front();
        chk("rdv_idx", r1dv, r.idx);
        chk("rdata", r.idx ? r1d : r0d, r.data);
        chk("other_rdata", r.idx ? r0d : r1d, 0);
        chk("rd_err", err, r.err);
        chk("rdv_cyc", cyc, r.cyc);
      end
      outst = 0;
    end else begin
      chk("rdata_idle", |{r0d, r1d, err}, 0);
      if (rsp_q.size() != 0 &&
          rsp_q[0].cyc < cyc) begin
        chk("rdv_missing", 0, 1);
        void'(rsp_q.pop_front());
        outst = 0;
      end
    end
  end

  // Downstream responder, runs after requesters.
  initial begin : resp
    int   cnt;
    int   gen;
    int   d;
    rsp_t cur;
    cnt    = 0;
    gen    = 0;
    m_rdy  = 0;
    m_dv   = 0;
    m_data = 0;
    forever begin
      @(posedge clk);
      #2;
      m_dv   = 0;
      m_data = 0;
      if (rdy_mode == 0)
        m_rdy = ($urandom_range(0, 3) != 0);
      else
        m_rdy = (rdy_mode == 2);
      if (hs_flag) begin
        hs_flag  = 0;
        gen      = rst_gen;
        cur.idx  = hs_item.idx;
        cur.data = frc_en ? frc_data : $urandom;
        cur.err  = 0;
        if (silent) begin
          cur.data = 32'hDEAD_BEEF;
          cur.err  = 1;
          cur.cyc  = cyc + TO;
          rsp_q.push_back(cur);
        end else begin
          d   = (fix_dly >= 0) ? fix_dly
                               : $urandom_range(0, 4);
          cnt = d + 1;
        end
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          m_dv   = 1;
          m_data = cur.data;
          if (gen == rst_gen) begin
            cur.cyc = cyc + 1;
            rsp_q.push_back(cur);
          end
        end
      end else if (spur_en &&
                   $urandom_range(0, 7) == 0) begin
        m_dv   = 1;
        m_data = 32'hBAD0_BAD0;
      end
      rbusy = (cnt > 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        acc[i] = 0;
        if (!hold_req) begin
          ra[i] = $urandom;
          rv[i] = auto_req &&
                  ($urandom_range(0, 1) == 1);
        end
      end else if (auto_req && !rv[i] &&
                   $urandom_range(0, 3) == 0) begin
        rv[i] = 1;
        ra[i] = $urandom;
      end
    end
  endtask

  task automatic quiesce(string nm);
    int k;
    k = 0;
    auto_req = 0;
    hold_req = 0;
    while ((outst || rv[0] || rv[1] || rbusy ||
            hs_flag || iss_q.size() != 0 ||
            rsp_q.size() != 0) && k < 300) begin
      step();
      k++;
    end
    chk(nm, k < 300, 1);
  endtask

  initial begin : stim
    int base;
    int t0;
    rst   = 1;
    rv[0] = 1;
    rv[1] = 1;
    ra[0] = 32'h4;
    ra[1] = 32'h8;
    hold_req = 1;
    repeat (3) step();
    rst = 0;
    for (int k = 0; k < 200 && glog.size() < 4; k++)
      step();
    chk("cont_cnt", glog.size(), 4);
    if (glog.size() >= 4) begin
      chk("cont_g0", glog[0], 0);
      chk("cont_g1", glog[1], 1);
      chk("cont_g2", glog[2], 0);
      chk("cont_g3", glog[3], 1);
    end
    rv[0] = 0;
    rv[1] = 0;
    quiesce("q_cont");
    chk("cont_mcnt", mlog.size(), 4);
    if (mlog.size() >= 4) begin
      chk("cont_a0", mlog[0], 32'h4);
      chk("cont_a1", mlog[1], 32'h8);
      chk("cont_a2", mlog[2], 32'h4);
      chk("cont_a3", mlog[3], 32'h8);
    end

    base     = glog.size();
    frc_en   = 1;
    frc_data = 32'h1234_5678;
    fix_dly  = 1;
    rv[0]    = 1;
    ra[0]    = 32'h10;
    step();
    quiesce("q_single");
    chk("single_gnts", glog.size() - base, 1);
    if (glog.size() > base)
      chk("single_idx", glog[base], 0);
    chk("single_addr", mlog[mlog.size() - 1], 32'h10);
    frc_en = 0;

    rdy_mode = 1;
    mv_rise  = -1;
    hs_cyc   = -1;
    base     = bp_cnt;
    rv[1]    = 1;
    ra[1]    = 32'h0A5A_5A50;
    for (int k = 0; k < 20 && mv_rise < 0; k++)
      step();
    t0 = mv_rise;
    repeat (4) step();
    rdy_mode = 2;
    quiesce("q_bp");
    rdy_mode = 0;
    chk("bp_hold", bp_cnt - base, 5);
    chk("bp_hs_cyc", hs_cyc, t0 + 5);

    hs_cyc  = -1;
    fix_dly = 6;
    rv[0]   = 1;
    ra[0]   = $urandom;
    for (int k = 0; k < 30 && hs_cyc < 0; k++)
      step();
    step();
    rst = 1;
    repeat (2) step();
    rst = 0;
    repeat (10) step();
    base  = glog.size();
    rv[0] = 1;
    rv[1] = 1;
    ra[0] = $urandom;
    ra[1] = $urandom;
    for (int k = 0; k < 20 && glog.size() == base; k++)
      step();
    chk("rst_gnt0", glog.size() > base, 1);
    if (glog.size() > base)
      chk("rst_gnt_idx", glog[base], 0);
    quiesce("q_rst");
    fix_dly = -1;

`ifdef AXIL_ARB_TIMEOUT_EN
    silent = 1;
    rv[1]  = 1;
    ra[1]  = 32'h20;
    step();
    quiesce("q_tmo");
    silent   = 0;
    fix_dly  = TO - 1;
    frc_en   = 1;
    frc_data = 32'hCAFE_F00D;
    rv[0]    = 1;
    ra[0]    = 32'h24;
    step();
    quiesce("q_tmo_edge");
    frc_en  = 0;
    fix_dly = -1;
`endif

    auto_req = 1;
    spur_en  = 1;
    repeat (3000) step();
    spur_en = 0;
    quiesce("q_rand");
    chk("final_empty",
        iss_q.size() + rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
